// File: rtl/posit_pkg.sv
// Shared posit types and constants for the multiplier/encoder path.
// Rounding mode is selected by POSIT_RNE_ROUND_EN (see posit_round).
package posit_pkg;

   localparam int POSIT_N  = 32;
   localparam int POSIT_ES = 2;
   localparam int POSIT_RS = $clog2(POSIT_N);
   localparam int POSIT_RW = POSIT_RS + 3;
   localparam int POSIT_WW = (POSIT_N - 1) + 2 * POSIT_N;

   function automatic logic [63:0] nar(input int n);
      return 64'd1 << (n - 1);
   endfunction

   function automatic logic [63:0] maxpos(input int n);
      return (64'd1 << (n - 1)) - 64'd1;
   endfunction

   function automatic logic [63:0] minpos(input int n);
      return (n > 1) ? 64'd1 : 64'd0;
   endfunction

   typedef struct packed {
      logic                         sign;
      logic signed [POSIT_RW-1:0]   sum_r;
      logic        [POSIT_RW-1:0]   r_len;
      logic        [POSIT_ES-1:0]   exp;
      logic        [2*POSIT_N-1:0]  mant;
      logic                         inf;
      logic                         zero;
   } posit_raw_t;

   typedef struct packed {
      logic                         sign;
      logic                         neg_k;
      logic                         sat;
      logic        [POSIT_WW-1:0]   body_ext;
      logic                         inf;
      logic                         zero;
   } posit_s1_t;

endpackage

// File: rtl/posit_round.sv
// Combinational rounding, saturation, special cases and negation of a stage-1 body.
// POSIT_RNE_ROUND_EN selects round-to-nearest-even; otherwise truncation.
module posit_round
   import posit_pkg::*;
#(
   parameter int N = POSIT_N
) (
   input  posit_s1_t        i_s1,
   output logic [N-1:0]     o_posit
);

   localparam int W = POSIT_WW;
   localparam logic [N-1:0] P_NAR  = N'(nar(N));
   localparam logic [N-1:0] P_MAXP = N'(maxpos(N));
   localparam logic [N-1:0] P_MINP = N'(minpos(N));

   logic [N-2:0] w_body;
   logic [N-2:0] w_body_fin;
   logic         w_guard;
   logic         w_sticky;
   logic [N-1:0] w_mag;

   function automatic logic [N-2:0] round_body(input logic [N-2:0] body,
                                               input logic guard,
                                               input logic sticky);
      logic [N-1:0] sum;
`ifdef POSIT_RNE_ROUND_EN
      sum = {1'b0, body} + N'(guard & (sticky | body[0]));
`else
      sum = {1'b0, body};
`endif
      // A carry out of the body would alias NaR; a nonzero value must not read as 0.
      if (sum[N-1]) return P_MAXP[N-2:0];
      if ((sum[N-2:0] == '0) && (guard || sticky)) return P_MINP[N-2:0];
      return sum[N-2:0];
   endfunction

   function automatic logic [N-2:0] sat_body(input logic neg_k);
      return neg_k ? P_MINP[N-2:0] : P_MAXP[N-2:0];
   endfunction

   assign w_body   = i_s1.body_ext[W-1 -: N-1];
   assign w_guard  = i_s1.body_ext[W-N];
   assign w_sticky = |i_s1.body_ext[W-N-1:0];

   always_comb begin
      w_body_fin = i_s1.sat ? sat_body(i_s1.neg_k) : round_body(w_body, w_guard, w_sticky);
      w_mag      = {1'b0, w_body_fin};
      o_posit    = w_mag;
      if (i_s1.inf)       o_posit = P_NAR;
      else if (i_s1.zero) o_posit = '0;
      else if (i_s1.sign) o_posit = -w_mag;
   end

endmodule

// File: rtl/posit_encode_pipe.sv
// Two-stage posit encoder: stage 1 builds the regime/exponent/fraction body,
// stage 2 registers the rounded posit. POSIT_RNE_ROUND_EN selects RNE rounding.
module posit_encode_pipe
   import posit_pkg::*;
#(
   parameter int N  = POSIT_N,
   parameter int ES = POSIT_ES,
   parameter int RS = POSIT_RS
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_sign,
   input  logic signed [RS+2:0] in_sum_r,
   input  logic        [RS+2:0] in_r_len,
   input  logic        [ES-1:0] in_exp,
   input  logic      [2*N-1:0] in_mant,
   input  logic                in_inf,
   input  logic                in_zero,
   output logic                out_valid,
   input  logic                out_ready,
   output logic        [N-1:0] out_posit
);

   localparam int RW = RS + 3;
   localparam int W  = (N - 1) + 2 * N;
   localparam int XW = W + N;

   posit_raw_t            w_raw;
   posit_s1_t             w_s1;
   posit_s1_t             r_s1_p1;
   logic                  r_vld_p1;
   logic                  r_vld_p2;
   logic [N-1:0]          r_posit_p2;
   logic [N-1:0]          w_posit;
   logic                  w_s2_en;
   logic                  w_in_ready;
   logic                  w_rbit;
   logic [ES+2*N-1:0]     w_tail;
   logic [XW-1:0]         w_shift;
   logic [XW-1:0]         w_fill;
   logic [XW-1:0]         w_ext;
   logic                  w_unused;

   assign w_raw = {in_sign, in_sum_r, in_r_len, in_exp, in_mant, in_inf, in_zero};

   // Only the regime sign and the fraction below the hidden bit shape the body.
   assign w_unused = ^{w_raw.sum_r[RW-2:0], w_raw.mant[2*N-1]};

   assign w_rbit  = ~w_raw.sum_r[RW-1];
   assign w_tail  = {~w_rbit, w_raw.exp, w_raw.mant[2*N-2:0]};
   assign w_shift = {w_tail, {(XW-ES-2*N){1'b0}}} >> w_raw.r_len;
   assign w_fill  = w_rbit ? ~({XW{1'b1}} >> w_raw.r_len) : '0;
   assign w_ext   = w_shift | w_fill;

   // Bits falling below the work vector are folded into its LSB so sticky stays exact.
   assign w_s1.sign     = w_raw.sign;
   assign w_s1.neg_k    = w_raw.sum_r[RW-1];
   assign w_s1.sat      = (w_raw.r_len >= RW'(N-1));
   assign w_s1.body_ext = {w_ext[XW-1 -: W-1], w_ext[XW-W] | (|w_ext[XW-W-1:0])};
   assign w_s1.inf      = w_raw.inf;
   assign w_s1.zero     = w_raw.zero;

   assign w_s2_en    = !r_vld_p2 || out_ready;
   assign w_in_ready = !r_vld_p1 || w_s2_en;

   // Stage 0 -> 1: capture the built body
   always_ff @(posedge clk) begin
      if (w_in_ready && in_valid) r_s1_p1 <= w_s1;
   end

   posit_round #(.N(N)) u_round (
      .i_s1    (r_s1_p1),
      .o_posit (w_posit)
   );

   // Stage 1 -> 2: rounded posit onto the result bus
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_vld_p1   <= 1'b0;
         r_vld_p2   <= 1'b0;
         r_posit_p2 <= '0;
      end else begin
         if (w_in_ready) r_vld_p1 <= in_valid;
         if (w_s2_en) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) r_posit_p2 <= w_posit;
         end
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_vld_p2;
   assign out_posit = r_posit_p2;

endmodule
